rv_lsu_split: RTL and testbench

Initiator-side load/store sequencer that sits between the Q103H execute/memory pipeline and rv_dmem_wrap. It drives the data-memory request port (addr/wr_data/wr_en/byte_en/is_signed in Q103H) and consumes rd_data in Q104H. Accesses that cross a 32-bit word boundary are broken into multiple aligned accesses: two word reads for loads, a sequence of byte writes for stores. While an access is split, the block stalls the pipeline, and it merges split load data in Q104H.

---
 rtl/rv_pkg.sv | 35 +++
 rtl/rv_lsu_load_merge.sv | 29 ++
 rtl/rv_lsu_split.sv | 175 +++++++++++++++++
 tb/tb_rv_lsu_split.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV core definitions used by the load/store sequencer:
// funct3 codes, byte-enable encodings and the split-access state type.
package rv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      LD_HI,
      ST_BYTES
   } t_lsu_state;

   // Size-encoded byte enable; the memory wrapper applies the address offset.
   function automatic logic [3:0] sizeToByteEn(input logic [1:0] size);
      logic [3:0] be;
      case (size)
         2'b00:   be = BE_B;
         2'b01:   be = BE_H;
         default: be = BE_W;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/rv_lsu_load_merge.sv
// Combines two aligned words of a split load into the final load result:
// shift the 64-bit {hi, lo} by the byte offset, truncate to size, extend.
module rv_lsu_load_merge
   import rv_pkg::*;
(
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_data
);

   logic [63:0] w_cat;
   logic [63:0] w_shift;

   assign w_cat   = {i_hi, i_lo};
   assign w_shift = w_cat >> {i_offset, 3'b000};

   always_comb begin
      o_data = w_shift[31:0];
      case (i_size)
         F3_LB[1:0]: o_data = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
         F3_LH[1:0]: o_data = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
         default:    o_data = w_shift[31:0];
      endcase
   end

endmodule

// File: rtl/rv_lsu_split.sv
// Load/store sequencer between the Q103H pipeline and rv_dmem_wrap; splits
// word-crossing loads into two word reads and stores into byte writes.
module rv_lsu_split
   import rv_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_Q103H,
   input  logic              req_wr_en_Q103H,
   input  logic [2:0]        req_funct3_Q103H,
   input  logic [ADDR_W-1:0] req_addr_Q103H,
   input  logic [31:0]       req_wr_data_Q103H,
   output logic              stall_Q103H,
   output logic              misaligned_Q103H,
   output logic [ADDR_W-1:0] dmem_addr_Q103H,
   output logic [31:0]       dmem_wr_data_Q103H,
   output logic              dmem_wr_en_Q103H,
   output logic [3:0]        dmem_byte_en_Q103H,
   output logic              dmem_is_signed_Q103H,
   input  logic [31:0]       dmem_rd_data_Q104H,
   output logic [31:0]       load_data_Q104H,
   output logic              load_valid_Q104H
);

   t_lsu_state        r_state;
   logic [1:0]        r_cnt;
   logic [31:0]       r_loBuf;
   logic              r_loadValid_Q104H;
   logic              r_split_Q104H;
   logic [1:0]        r_offset_Q104H;
   logic [1:0]        r_size_Q104H;
   logic              r_signed_Q104H;

   logic [1:0]        w_size;
   logic [1:0]        w_offset;
   logic              w_cross;
   logic              w_doSplit;
   logic [1:0]        w_lastByte;
   logic [ADDR_W-1:0] w_alignAddr;
   logic              w_loadIssue;
   logic              w_stall;
   logic              w_misaligned;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wrData;
   logic              w_wrEn;
   logic [3:0]        w_byteEn;
   logic              w_isSigned;
   logic [31:0]       w_merged;

   assign w_size      = req_funct3_Q103H[1:0];
   assign w_offset    = req_addr_Q103H[1:0];
   assign w_cross     = ((w_size == F3_LH[1:0]) && (w_offset == 2'b11)) ||
                        ((w_size == F3_LW[1:0]) && (w_offset != 2'b00));
   assign w_doSplit   = SPLIT_EN && req_valid_Q103H && w_cross;
   assign w_lastByte  = (req_funct3_Q103H == F3_SW) ? 2'd3 : 2'd1;
   assign w_alignAddr = {req_addr_Q103H[ADDR_W-1:2], 2'b00};

   always_comb begin
      w_stall      = 1'b0;
      w_misaligned = 1'b0;
      w_addr       = req_addr_Q103H;
      w_wrData     = req_wr_data_Q103H;
      w_wrEn       = req_valid_Q103H & req_wr_en_Q103H;
      w_byteEn     = sizeToByteEn(w_size);
      w_isSigned   = ~req_funct3_Q103H[2];
      w_loadIssue  = req_valid_Q103H & ~req_wr_en_Q103H;
      case (r_state)
         IDLE: begin
            w_misaligned = req_valid_Q103H & w_cross;
            if (w_doSplit) begin
               w_stall     = 1'b1;
               w_loadIssue = 1'b0;
               w_byteEn    = req_wr_en_Q103H ? BE_B : BE_W;
               w_isSigned  = 1'b0;
               if (req_wr_en_Q103H) begin
                  w_wrData = {24'b0, req_wr_data_Q103H[7:0]};
               end else begin
                  w_addr = w_alignAddr;
               end
            end
         end
         LD_HI: begin
            w_addr      = w_alignAddr + ADDR_W'(4);
            w_wrEn      = 1'b0;
            w_byteEn    = BE_W;
            w_isSigned  = 1'b0;
            w_loadIssue = 1'b1;
         end
         ST_BYTES: begin
            w_stall     = (r_cnt != w_lastByte);
            w_addr      = req_addr_Q103H + ADDR_W'(r_cnt);
            w_wrData    = {24'b0, req_wr_data_Q103H[{r_cnt, 3'b000} +: 8]};
            w_wrEn      = 1'b1;
            w_byteEn    = BE_B;
            w_isSigned  = 1'b0;
            w_loadIssue = 1'b0;
         end
         default: begin
            w_wrEn      = 1'b0;
            w_loadIssue = 1'b0;
         end
      endcase
   end

   // Reset must silence the request port at once, even mid-split, so the
   // combinational outputs are gated by rst_n as well as the state.
   assign stall_Q103H          = rst_n & w_stall;
   assign misaligned_Q103H     = rst_n & w_misaligned;
   assign dmem_addr_Q103H      = rst_n ? w_addr : '0;
   assign dmem_wr_data_Q103H   = rst_n ? w_wrData : '0;
   assign dmem_wr_en_Q103H     = rst_n & w_wrEn;
   assign dmem_byte_en_Q103H   = rst_n ? w_byteEn : 4'b0000;
   assign dmem_is_signed_Q103H = rst_n & w_isSigned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= IDLE;
         r_cnt             <= 2'd0;
         r_loBuf           <= 32'd0;
         r_loadValid_Q104H <= 1'b0;
         r_split_Q104H     <= 1'b0;
         r_offset_Q104H    <= 2'd0;
         r_size_Q104H      <= 2'd0;
         r_signed_Q104H    <= 1'b0;
      end else begin
         r_loadValid_Q104H <= w_loadIssue;
         r_split_Q104H     <= (r_state == LD_HI);
         r_offset_Q104H    <= w_offset;
         r_size_Q104H      <= w_size;
         r_signed_Q104H    <= ~req_funct3_Q103H[2];
         case (r_state)
            IDLE: begin
               r_cnt <= 2'd0;
               if (w_doSplit) begin
                  r_state <= req_wr_en_Q103H ? ST_BYTES : LD_HI;
                  r_cnt   <= 2'd1;
               end
            end
            LD_HI: begin
               r_loBuf <= dmem_rd_data_Q104H;
               r_state <= IDLE;
            end
            ST_BYTES: begin
               if (r_cnt == w_lastByte) begin
                  r_state <= IDLE;
                  r_cnt   <= 2'd0;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   rv_lsu_load_merge u_merge (
      .i_hi     (dmem_rd_data_Q104H),
      .i_lo     (r_loBuf),
      .i_offset (r_offset_Q104H),
      .i_size   (r_size_Q104H),
      .i_signed (r_signed_Q104H),
      .o_data   (w_merged)
   );

   assign load_valid_Q104H = r_loadValid_Q104H;
   assign load_data_Q104H  = !rst_n        ? 32'd0 :
                             r_split_Q104H ? w_merged : dmem_rd_data_Q104H;

endmodule

// File: tb/tb_rv_lsu_split.sv
// Directed bench for rv_lsu_split with a small byte-addressed memory model
// standing in for rv_dmem_wrap, plus a SPLIT_EN=0 instance.
module tb_rv_lsu_split;

   logic        clk;
   logic        rst_n;
   logic        reqValid;
   logic        reqWrEn;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr;
   logic [31:0] reqWrData;
   logic        stall;
   logic        misaligned;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWrData;
   logic        dmemWrEn;
   logic [3:0]  dmemByteEn;
   logic        dmemIsSigned;
   logic [31:0] dmemRdData;
   logic [31:0] loadData;
   logic        loadValid;

   logic        nsReqValid;
   logic [31:0] nsReqAddr;
   logic        nsStall;
   logic        nsMisaligned;
   logic [31:0] nsDmemAddr;
   logic [31:0] nsDmemWrData;
   logic        nsDmemWrEn;
   logic [3:0]  nsDmemByteEn;
   logic        nsDmemIsSigned;
   logic [31:0] nsLoadData;
   logic        nsLoadValid;

   logic [7:0]  mem [64];
   logic        memInit;
   int          nCompared;
   int          nMismatched;

   rv_lsu_split #(.SPLIT_EN(1'b1), .ADDR_W(32)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid_Q103H      (reqValid),
      .req_wr_en_Q103H      (reqWrEn),
      .req_funct3_Q103H     (reqFunct3),
      .req_addr_Q103H       (reqAddr),
      .req_wr_data_Q103H    (reqWrData),
      .stall_Q103H          (stall),
      .misaligned_Q103H     (misaligned),
      .dmem_addr_Q103H      (dmemAddr),
      .dmem_wr_data_Q103H   (dmemWrData),
      .dmem_wr_en_Q103H     (dmemWrEn),
      .dmem_byte_en_Q103H   (dmemByteEn),
      .dmem_is_signed_Q103H (dmemIsSigned),
      .dmem_rd_data_Q104H   (dmemRdData),
      .load_data_Q104H      (loadData),
      .load_valid_Q104H     (loadValid)
   );

   rv_lsu_split #(.SPLIT_EN(1'b0), .ADDR_W(32)) u_dutNoSplit (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid_Q103H      (nsReqValid),
      .req_wr_en_Q103H      (1'b0),
      .req_funct3_Q103H     (3'b010),
      .req_addr_Q103H       (nsReqAddr),
      .req_wr_data_Q103H    (32'd0),
      .stall_Q103H          (nsStall),
      .misaligned_Q103H     (nsMisaligned),
      .dmem_addr_Q103H      (nsDmemAddr),
      .dmem_wr_data_Q103H   (nsDmemWrData),
      .dmem_wr_en_Q103H     (nsDmemWrEn),
      .dmem_byte_en_Q103H   (nsDmemByteEn),
      .dmem_is_signed_Q103H (nsDmemIsSigned),
      .dmem_rd_data_Q104H   (32'h0BAD_F00D),
      .load_data_Q104H      (nsLoadData),
      .load_valid_Q104H     (nsLoadValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: the wrapper applies the address offset to the size-encoded
   // byte enable and returns extended read data one cycle later.
   function automatic logic [31:0] readMem(input logic [31:0] addr,
                                           input logic [3:0] be,
                                           input logic sgn);
      logic [31:0] val;
      val = {mem[6'(addr + 32'd3)], mem[6'(addr + 32'd2)],
             mem[6'(addr + 32'd1)], mem[6'(addr)]};
      if (be == 4'b0001)      val = {{24{sgn & val[7]}}, val[7:0]};
      else if (be == 4'b0011) val = {{16{sgn & val[15]}}, val[15:0]};
      return val;
   endfunction

   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
         mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
         mem[4] <= 8'hD5; mem[5] <= 8'h66; mem[6] <= 8'h77; mem[7] <= 8'h88;
         dmemRdData <= 32'd0;
      end else begin
         if (dmemWrEn) begin
            for (int i = 0; i < 4; i++)
               if (dmemByteEn[i]) mem[6'(dmemAddr + 32'(i))] <= dmemWrData[8*i +: 8];
         end
         dmemRdData <= readMem(dmemAddr, dmemByteEn, dmemIsSigned);
      end
   end

   // Every comparison in the bench passes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data);
      reqValid  = valid;
      reqWrEn   = wr;
      reqFunct3 = f3;
      reqAddr   = addr;
      reqWrData = data;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Split load: lo read, hi read, then the merged result for one cycle.
   task automatic splitLoad(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] expData);
      logic [31:0] aligned;
      aligned = addr & 32'hFFFF_FFFC;
      applyStimulus(1'b1, 1'b0, f3, addr, 32'd0);
      @(negedge clk);
      checkOutput({tag, " mis c0"}, 32'(misaligned), 32'd1);
      checkOutput({tag, " stall c0"}, 32'(stall), 32'd1);
      checkOutput({tag, " addr c0"}, dmemAddr, aligned);
      checkOutput({tag, " be c0"}, 32'(dmemByteEn), 32'hF);
      nextCycle();
      @(negedge clk);
      checkOutput({tag, " mis c1"}, 32'(misaligned), 32'd0);
      checkOutput({tag, " stall c1"}, 32'(stall), 32'd0);
      checkOutput({tag, " addr c1"}, dmemAddr, aligned + 32'd4);
      checkOutput({tag, " lv c1"}, 32'(loadValid), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput({tag, " lv c2"}, 32'(loadValid), 32'd1);
      checkOutput({tag, " data"}, loadData, expData);
      nextCycle();
      @(negedge clk);
      checkOutput({tag, " lv c3"}, 32'(loadValid), 32'd0);
      nextCycle();
   endtask

   initial begin
      logic [7:0] swBytes [4];
      nCompared   = 0;
      nMismatched = 0;
      memInit     = 1'b1;
      rst_n       = 1'b0;
      nsReqValid  = 1'b0;
      nsReqAddr   = 32'd0;
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h12, 32'h55);
      #2;
      checkOutput("rst stall", 32'(stall), 32'd0);
      checkOutput("rst mis", 32'(misaligned), 32'd0);
      checkOutput("rst wren", 32'(dmemWrEn), 32'd0);
      checkOutput("rst addr", dmemAddr, 32'd0);
      checkOutput("rst wdata", dmemWrData, 32'd0);
      checkOutput("rst lv", 32'(loadValid), 32'd0);
      checkOutput("rst ldata", loadData, 32'd0);
      nextCycle();
      nextCycle();
      memInit = 1'b0;
      rst_n   = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      nextCycle();

      $display("[TB] aligned LW addr 0");
      applyStimulus(1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("lw0 stall", 32'(stall), 32'd0);
      checkOutput("lw0 mis", 32'(misaligned), 32'd0);
      checkOutput("lw0 addr", dmemAddr, 32'd0);
      checkOutput("lw0 wren", 32'(dmemWrEn), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("lw0 lv", 32'(loadValid), 32'd1);
      checkOutput("lw0 data", loadData, 32'h4433_2211);
      nextCycle();
      @(negedge clk);
      checkOutput("idle lv", 32'(loadValid), 32'd0);
      checkOutput("idle wren", 32'(dmemWrEn), 32'd0);
      nextCycle();

      $display("[TB] split loads");
      splitLoad("lw2", 3'b010, 32'd2, 32'h66D5_4433);
      splitLoad("lh3", 3'b001, 32'd3, 32'hFFFF_D544);
      splitLoad("lhu3", 3'b101, 32'd3, 32'h0000_D544);

      $display("[TB] split SW addr 5");
      swBytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      applyStimulus(1'b1, 1'b1, 3'b010, 32'd5, 32'hAABB_CCDD);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("sw5 addr k%0d", k), dmemAddr, 32'(5 + k));
         checkOutput($sformatf("sw5 data k%0d", k), dmemWrData, {24'd0, swBytes[k]});
         checkOutput($sformatf("sw5 be k%0d", k), 32'(dmemByteEn), 32'h1);
         checkOutput($sformatf("sw5 wren k%0d", k), 32'(dmemWrEn), 32'd1);
         checkOutput($sformatf("sw5 stall k%0d", k), 32'(stall), (k < 3) ? 32'd1 : 32'd0);
         checkOutput($sformatf("sw5 mis k%0d", k), 32'(misaligned), (k == 0) ? 32'd1 : 32'd0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
      @(negedge clk);
      checkOutput("lw4 stall", 32'(stall), 32'd0);
      checkOutput("lw4 addr", dmemAddr, 32'd4);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 3'b100, 32'd8, 32'd0);
      @(negedge clk);
      checkOutput("lw4 lv", 32'(loadValid), 32'd1);
      checkOutput("lw4 data", loadData, 32'hBBCC_DDD5);
      checkOutput("lbu8 be", 32'(dmemByteEn), 32'h1);
      checkOutput("lbu8 sgn", 32'(dmemIsSigned), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("lbu8 data", loadData, 32'h0000_00AA);
      nextCycle();

      $display("[TB] SW addr 9 aborted by reset");
      applyStimulus(1'b1, 1'b1, 3'b010, 32'd9, 32'h1122_3344);
      @(negedge clk);
      checkOutput("sw9 data k0", dmemWrData, 32'h44);
      nextCycle();
      @(negedge clk);
      checkOutput("sw9 addr k1", dmemAddr, 32'd10);
      nextCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("abort stall", 32'(stall), 32'd0);
      checkOutput("abort wren", 32'(dmemWrEn), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      rst_n = 1'b1;
      nextCycle();
      @(negedge clk);
      checkOutput("abort lv", 32'(loadValid), 32'd0);
      checkOutput("mem9", 32'(mem[9]), 32'h44);
      checkOutput("mem10", 32'(mem[10]), 32'h33);
      checkOutput("mem11", 32'(mem[11]), 32'h0B);
      checkOutput("mem12", 32'(mem[12]), 32'h0C);
      nextCycle();

      $display("[TB] SPLIT_EN=0 LW addr 2");
      nsReqValid = 1'b1;
      nsReqAddr  = 32'd2;
      @(negedge clk);
      checkOutput("ns mis", 32'(nsMisaligned), 32'd1);
      checkOutput("ns stall c0", 32'(nsStall), 32'd0);
      checkOutput("ns addr", nsDmemAddr, 32'd2);
      checkOutput("ns be", 32'(nsDmemByteEn), 32'hF);
      nextCycle();
      nsReqValid = 1'b0;
      @(negedge clk);
      checkOutput("ns stall c1", 32'(nsStall), 32'd0);
      checkOutput("ns lv", 32'(nsLoadValid), 32'd1);
      checkOutput("ns data", nsLoadData, 32'h0BAD_F00D);
      nextCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
